// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
//
// Execute stage that sits directly behind the 16-bit register bank. It takes
// the two read-port operands, computes a result with a small multi-cycle ALU,
// and then presents one write to the bank on Sel_C/Data_C for exactly one
// cycle. While idle, Sel_C stays on NULL_SEL, which maps to no register, so
// the bank's always-write port does not write anything.
//
// Ports
//   clk       in   1      system clock, rising edge
//   nreset    in   1      asynchronous active-low reset
//   start     in   1      request, sampled only while busy=0
//   op        in   4      operation code, sampled with start
//   dest_sel  in   SEL_W  destination register, sampled with start
//   Data_A    in   WIDTH  operand A, sampled with start
//   Data_B    in   WIDTH  operand B, sampled with start
//   busy      out  1      operation in progress
//   done      out  1      one-cycle completion strobe
//   Sel_C     out  SEL_W  write select to the bank
//   Data_C    out  WIDTH  write data to the bank
//   flags     out  4      {Z,N,C,V}
//
// Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL, 7 SHR,
//           8 MUL (low half), 9 PASS B, 10-15 PASS A
// ---------------------------------------------------------------------------
module alu_exec_stage #(
  parameter int WIDTH    = 16,
  parameter int SEL_W    = 6,
  parameter int NULL_SEL = 63
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [SEL_W-1:0] dest_sel,
  input  logic [WIDTH-1:0] Data_A,
  input  logic [WIDTH-1:0] Data_B,
  output logic             busy,
  output logic             done,
  output logic [SEL_W-1:0] Sel_C,
  output logic [WIDTH-1:0] Data_C,
  output logic [3:0]       flags
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [SEL_W-1:0] nullSel = SEL_W'(NULL_SEL);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_PASB = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    ITER,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [SEL_W-1:0] dest_q, dest_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] workHi_q, workHi_d;
  logic [WIDTH-1:0] workLo_q, workLo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [SEL_W-1:0] selC_q, selC_d;
  logic [WIDTH-1:0] dataC_q, dataC_d;
  logic [3:0]       flags_q, flags_d;

  // Single-cycle ALU results, computed from the captured operands.
  logic [WIDTH:0]   aluSum;
  logic [WIDTH:0]   aluDiff;
  logic [WIDTH-1:0] aluRes;
  logic             aluC;
  logic             aluV;

  // One iteration step for shifts and the shift-add multiplier.
  logic [WIDTH-1:0] shiftLo;
  logic             shiftOut;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH-1:0] stepHi;
  logic [WIDTH-1:0] stepLo;
  logic             stepC;

  // Completion request from the FSM, applied to the output registers.
  logic             fin;
  logic [WIDTH-1:0] finRes;
  logic             finC;
  logic             finV;

  logic             isShift;

  assign isShift = (op_q == OP_SHL) || (op_q == OP_SHR);

  // Combinational ALU for the ops that finish in the EXEC cycle. The 17-bit
  // difference wraps when A<B, so its top bit is the unsigned borrow.
  always_comb begin
    aluSum  = {1'b0, a_q} + {1'b0, b_q};
    aluDiff = {1'b0, a_q} - {1'b0, b_q};
    aluRes  = a_q;
    aluC    = 1'b0;
    aluV    = 1'b0;
    case (op_q)
      OP_ADD: begin
        aluRes = aluSum[WIDTH-1:0];
        aluC   = aluSum[WIDTH];
        aluV   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                 (aluSum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        aluRes = aluDiff[WIDTH-1:0];
        aluC   = aluDiff[WIDTH];
        aluV   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                 (aluDiff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND:  aluRes = a_q & b_q;
      OP_OR:   aluRes = a_q | b_q;
      OP_XOR:  aluRes = a_q ^ b_q;
      OP_NOT:  aluRes = ~a_q;
      OP_PASB: aluRes = b_q;
      default: aluRes = a_q;
    endcase
  end

  // Iteration datapath. Shifts move workLo by one bit and remember the bit
  // that fell out. The multiplier keeps {workHi,workLo} as a combined
  // product/multiplier register: add A into the high half when the current
  // multiplier LSB is set, then shift the whole thing right by one, so after
  // WIDTH steps it holds the full double-width product.
  always_comb begin
    if (op_q[0]) begin
      shiftLo  = workLo_q >> 1;
      shiftOut = workLo_q[0];
    end else begin
      shiftLo  = workLo_q << 1;
      shiftOut = workLo_q[WIDTH-1];
    end

    mulSum = {1'b0, workHi_q} + (workLo_q[0] ? {1'b0, a_q} : '0);

    if (op_q == OP_MUL) begin
      stepHi = mulSum[WIDTH:1];
      stepLo = {mulSum[0], workLo_q[WIDTH-1:1]};
      stepC  = |mulSum[WIDTH:1];
    end else begin
      stepHi = workHi_q;
      stepLo = shiftLo;
      stepC  = shiftOut;
    end
  end

  // Next-state and output logic. Outputs are all registered, so the values
  // seen during the DONE cycle are loaded here on the edge that enters DONE.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dest_d   = dest_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    workHi_d = workHi_q;
    workLo_d = workLo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    selC_d   = nullSel;
    dataC_d  = dataC_q;
    flags_d  = flags_q;
    fin      = 1'b0;
    finRes   = '0;
    finC     = 1'b0;
    finV     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          dest_d  = dest_sel;
          a_d     = Data_A;
          b_d     = Data_B;
          busy_d  = 1'b1;
          state_d = EXEC;
        end
      end

      EXEC: begin
        if (isShift) begin
          if (b_q[3:0] == 4'd0) begin
            fin    = 1'b1;
            finRes = a_q;
          end else begin
            cnt_d    = CNT_W'(b_q[3:0]);
            workHi_d = '0;
            workLo_d = a_q;
            state_d  = ITER;
          end
        end else if (op_q == OP_MUL) begin
          cnt_d    = CNT_W'(WIDTH);
          workHi_d = '0;
          workLo_d = b_q;
          state_d  = ITER;
        end else begin
          fin    = 1'b1;
          finRes = aluRes;
          finC   = aluC;
          finV   = aluV;
        end
      end

      ITER: begin
        workHi_d = stepHi;
        workLo_d = stepLo;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          fin    = 1'b1;
          finRes = stepLo;
          finC   = stepC;
        end
      end

      DONE: begin
        // Back-to-back: a request in the DONE cycle skips IDLE entirely.
        if (start) begin
          op_d    = op;
          dest_d  = dest_sel;
          a_d     = Data_A;
          b_d     = Data_B;
          busy_d  = 1'b1;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (fin) begin
      state_d = DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      selC_d  = dest_q;
      dataC_d = finRes;
      flags_d = {(finRes == '0), finRes[WIDTH-1], finC, finV};
    end
  end

  // State and output registers. Reset aborts any operation in flight, and
  // because Sel_C returns to NULL_SEL no write reaches the bank.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      dest_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      workHi_q <= '0;
      workLo_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      selC_q   <= nullSel;
      dataC_q  <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dest_q   <= dest_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      workHi_q <= workHi_d;
      workLo_q <= workLo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      selC_q   <= selC_d;
      dataC_q  <= dataC_d;
      flags_q  <= flags_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign Sel_C  = selC_q;
  assign Data_C = dataC_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_stage
//
// Self-checking bench for alu_exec_stage: a table of hand-computed vectors,
// a batch of random operations checked against a plain-arithmetic reference
// model, and hand-written sequences for reset, back-to-back issue and an
// aborted multiply.
// ---------------------------------------------------------------------------
module tb_alu_exec_stage;

  localparam int WIDTH = 16;
  localparam int SEL_W = 6;
  localparam logic [5:0] NULL_SEL = 6'd63;

  logic        clk;
  logic        nreset;
  logic        start;
  logic [3:0]  op;
  logic [5:0]  dest_sel;
  logic [15:0] Data_A;
  logic [15:0] Data_B;
  logic        busy;
  logic        done;
  logic [5:0]  Sel_C;
  logic [15:0] Data_C;
  logic [3:0]  flags;

  int assertions = 0;
  int failures   = 0;

  logic [15:0] prevData  = 16'h0000;
  logic [3:0]  prevFlags = 4'h0;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [5:0]  dest;
    logic [15:0] expR;
    logic [3:0]  expF;
    int          expL;
    bit          scramble;
  } vec_t;

  vec_t vecs[16];

  alu_exec_stage #(
    .WIDTH(WIDTH),
    .SEL_W(SEL_W),
    .NULL_SEL(63)
  ) dut (
    .clk(clk),
    .nreset(nreset),
    .start(start),
    .op(op),
    .dest_sel(dest_sel),
    .Data_A(Data_A),
    .Data_B(Data_B),
    .busy(busy),
    .done(done),
    .Sel_C(Sel_C),
    .Data_C(Data_C),
    .flags(flags)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one packed observation against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive the request inputs.
  task automatic applyStimulus(input logic st, input logic [3:0] o, input logic [15:0] a,
                               input logic [15:0] b, input logic [5:0] d);
    start    = st;
    op       = o;
    Data_A   = a;
    Data_B   = b;
    dest_sel = d;
  endtask

  // Reference model computed straight from the op definitions.
  task automatic model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] r, output logic [3:0] f, output int lat);
    int          n;
    int          sa;
    int          sb;
    int          sr;
    logic [16:0] s;
    logic [31:0] p;
    logic        c;
    logic        v;
    n   = int'(b[3:0]);
    sa  = $signed(a);
    sb  = $signed(b);
    c   = 1'b0;
    v   = 1'b0;
    lat = 0;
    case (o)
      4'd0: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[15:0];
        c  = s[16];
        sr = sa + sb;
        v  = (sr > 32767) || (sr < -32768);
      end
      4'd1: begin
        r  = a - b;
        c  = (a < b);
        sr = sa - sb;
        v  = (sr > 32767) || (sr < -32768);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin
        lat = n;
        r   = a << n;
        c   = (n == 0) ? 1'b0 : a[16-n];
      end
      4'd7: begin
        lat = n;
        r   = a >> n;
        c   = (n == 0) ? 1'b0 : a[n-1];
      end
      4'd8: begin
        lat = 16;
        p   = {16'h0000, a} * {16'h0000, b};
        r   = p[15:0];
        c   = (p[31:16] != 16'h0000);
      end
      4'd9:    r = b;
      default: r = a;
    endcase
    f = {(r == 16'h0000), r[15], c, v};
  endtask

  // Issue one operation from idle and follow it to completion, checking the
  // busy phase, latency, the DONE cycle and the cycle after it.
  task automatic runOp(input string name, input logic [3:0] o, input logic [15:0] a,
                       input logic [15:0] b, input logic [5:0] d, input logic [15:0] expR,
                       input logic [3:0] expF, input int expL, input bit scramble);
    int k;
    applyStimulus(1'b1, o, a, b, d);
    @(posedge clk); #1;
    k = 0;
    while (k < 40) begin
      if (done) break;
      checkOutput({name, " busy phase"}, {4'b0, busy, done, Sel_C, Data_C, flags},
                  {4'b0, 1'b1, 1'b0, NULL_SEL, prevData, prevFlags});
      if (scramble)
        applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom),
                      16'($urandom), 6'($urandom));
      else
        start = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    checkOutput({name, " latency"}, k, expL + 1);
    checkOutput({name, " done cycle"}, {5'b0, busy, Sel_C, Data_C, flags},
                {5'b0, 1'b0, d, expR, expF});
    prevData  = expR;
    prevFlags = expF;
    @(posedge clk); #1;
    checkOutput({name, " after done"}, {5'b0, done, Sel_C, Data_C, flags},
                {5'b0, 1'b0, NULL_SEL, expR, expF});
  endtask

  initial begin
    logic [15:0] r;
    logic [3:0]  f;
    int          lat;
    logic        bad;

    // Hand-computed vectors: op, A, B, dest, result, {Z,N,C,V}, latency, scramble.
    vecs[0]  = '{4'd0, 16'h7FFF, 16'h0001, 6'd5,  16'h8000, 4'b0101, 0,  1'b0};
    vecs[1]  = '{4'd1, 16'h0003, 16'h0005, 6'd2,  16'hFFFE, 4'b0110, 0,  1'b0};
    vecs[2]  = '{4'd6, 16'h8001, 16'h0004, 6'd7,  16'h0010, 4'b0000, 4,  1'b0};
    vecs[3]  = '{4'd6, 16'h8001, 16'h0000, 6'd7,  16'h8001, 4'b0100, 0,  1'b0};
    vecs[4]  = '{4'd8, 16'h0100, 16'h0300, 6'd9,  16'h0000, 4'b1010, 16, 1'b1};
    vecs[5]  = '{4'd2, 16'hF0F0, 16'h3C3C, 6'd3,  16'h3030, 4'b0000, 0,  1'b0};
    vecs[6]  = '{4'd7, 16'h8001, 16'h0001, 6'd4,  16'h4000, 4'b0010, 1,  1'b0};
    vecs[7]  = '{4'd5, 16'h0000, 16'h1234, 6'd6,  16'hFFFF, 4'b0100, 0,  1'b0};
    vecs[8]  = '{4'd9, 16'h1234, 16'h0000, 6'd8,  16'h0000, 4'b1000, 0,  1'b0};
    vecs[9]  = '{4'd12, 16'hABCD, 16'h0001, 6'd10, 16'hABCD, 4'b0100, 0, 1'b0};
    vecs[10] = '{4'd0, 16'hFFFF, 16'h0001, 6'd11, 16'h0000, 4'b1010, 0,  1'b0};
    vecs[11] = '{4'd1, 16'h8000, 16'h0001, 6'd12, 16'h7FFF, 4'b0001, 0,  1'b0};
    vecs[12] = '{4'd4, 16'hFFFF, 16'h00FF, 6'd13, 16'hFF00, 4'b0100, 0,  1'b0};
    vecs[13] = '{4'd3, 16'h0F00, 16'h00F0, 6'd14, 16'h0FF0, 4'b0000, 0,  1'b0};
    vecs[14] = '{4'd0, 16'h0001, 16'h0001, 6'd63, 16'h0002, 4'b0000, 0,  1'b0};
    vecs[15] = '{4'd7, 16'h8000, 16'h000F, 6'd40, 16'h0001, 4'b0000, 15, 1'b1};

    nreset = 1'b1;
    applyStimulus(1'b0, 4'd0, 16'h0000, 16'h0000, 6'd0);
    #1 nreset = 1'b0;
    #20;
    checkOutput("reset state", {4'b0, busy, done, Sel_C, Data_C, flags},
                {4'b0, 1'b0, 1'b0, NULL_SEL, 16'h0000, 4'h0});
    @(posedge clk); #1;
    nreset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("idle after reset", {4'b0, busy, done, Sel_C, Data_C, flags},
                  {4'b0, 1'b0, 1'b0, NULL_SEL, 16'h0000, 4'h0});
    end

    // Table-driven vectors.
    for (int i = 0; i < 16; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest,
            vecs[i].expR, vecs[i].expF, vecs[i].expL, vecs[i].scramble);
    end

    // Back-to-back: second request accepted in the DONE cycle of the first.
    applyStimulus(1'b1, 4'd1, 16'h0003, 16'h0003, 6'd1);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("b2b first done", {4'b0, busy, done, Sel_C, Data_C, flags},
                {4'b0, 1'b0, 1'b1, 6'd1, 16'h0000, 4'b1000});
    applyStimulus(1'b1, 4'd10, 16'h5A5A, 16'h0000, 6'd8);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("b2b second busy", {4'b0, busy, done, Sel_C, Data_C, flags},
                {4'b0, 1'b1, 1'b0, NULL_SEL, 16'h0000, 4'b1000});
    @(posedge clk); #1;
    checkOutput("b2b second done", {4'b0, busy, done, Sel_C, Data_C, flags},
                {4'b0, 1'b0, 1'b1, 6'd8, 16'h5A5A, 4'b0000});
    @(posedge clk); #1;
    checkOutput("b2b after done", {5'b0, done, Sel_C, Data_C, flags},
                {5'b0, 1'b0, NULL_SEL, 16'h5A5A, 4'b0000});
    prevData  = 16'h5A5A;
    prevFlags = 4'b0000;

    // Abort a multiply mid-iteration with an asynchronous reset.
    applyStimulus(1'b1, 4'd8, 16'h0100, 16'h0300, 6'd9);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    #2 nreset = 1'b0;
    #1;
    checkOutput("abort reset outputs", {4'b0, busy, done, Sel_C, Data_C, flags},
                {4'b0, 1'b0, 1'b0, NULL_SEL, 16'h0000, 4'h0});
    @(posedge clk); #1;
    nreset = 1'b1;
    prevData  = 16'h0000;
    prevFlags = 4'h0;
    bad = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy || (Sel_C !== NULL_SEL)) bad = 1'b1;
    end
    checkOutput("no write after abort", {31'b0, bad}, 32'h0);

    // Random operations against the reference model, with request/operand
    // noise injected while busy.
    for (int i = 0; i < 60; i++) begin
      logic [3:0]  o;
      logic [15:0] a;
      logic [15:0] b;
      logic [5:0]  d;
      o = 4'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      d = 6'($urandom);
      model(o, a, b, r, f, lat);
      runOp($sformatf("rand%0d op%0d", i, o), o, a, b, d, r, f, lat, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage directly downstream of the 16-bit register bank.
- Consumes the two read-port operands (A/B) and computes the result with a small multi-cycle ALU.
- Drives the bank's write-select and write-data (Sel_C/Data_C) for exactly one cycle per operation.
- Keeps the write-select parked on a non-existent register while idle, so the bank's always-write port performs no write.

Parameters:
- WIDTH, 16, operand/result width.
- SEL_W, 6, width of the register-bank write select.
- NULL_SEL, 63, idle write-select value. It maps to no register, so no enable bit is set.

Ports:
- clk  in  1  system clock, rising edge.
- nreset  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- op  in  4  operation code, sampled with start.
- dest_sel  in  SEL_W  destination register, sampled with start.
- Data_A  in  WIDTH  operand A from the bank, sampled with start.
- Data_B  in  WIDTH  operand B from the bank, sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion strobe.
- Sel_C  out  SEL_W  write select to the bank.
- Data_C  out  WIDTH  write data to the bank.
- flags  out  4  {Z,N,C,V}.

Behaviour:
- Reset (async, nreset=0): state=IDLE, busy=0, done=0, Sel_C=NULL_SEL, Data_C=0, flags=0. Assertion mid-operation aborts the operation; no write is issued.
- All outputs are registered.
- States:
  - IDLE: start=1 latches op, dest_sel, A, B, and sets busy=1. Next state is EXEC.
  - EXEC: single-cycle ops compute the result and go to DONE. Iterative ops load the counter and go to ITER. A shift with count 0 goes straight to DONE.
  - ITER: one bit-step per cycle; counter decrements. Goes to DONE when the counter reaches 0.
  - DONE: this is the only cycle with Sel_C=dest and Data_C=result. busy=0, done=1, and start may be accepted (back-to-back). Next state is IDLE, or EXEC if start was accepted.
- Latency: with start sampled at edge E0, done=1 in the cycle after edge E(1+L).
  - L=0 for ops 0-5, 9-15.
  - L=B[3:0] for ops 6-7.
  - L=16 for op 8.
- busy=1 for the cycles between E0 and that edge.
- Outside DONE: Sel_C=NULL_SEL and Data_C holds its last value.
- Ops:
  - 0 ADD A+B
  - 1 SUB A-B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT A
  - 6 SHL A by B[3:0], logical, 1 bit/cycle
  - 7 SHR A by B[3:0], logical, 1 bit/cycle
  - 8 MUL: low 16 bits of A*B, shift-add, 1 bit/cycle
  - 9 PASS B
  - 10-15 PASS A
- Arithmetic is modulo 2^WIDTH.
- Flags are updated only on the edge entering DONE and held otherwise:
  - Z = result==0.
  - N = result[15].
  - C:
    - ADD: carry out.
    - SUB: borrow (A<B unsigned).
    - Shifts: last bit shifted out; 0 if count 0.
    - MUL: upper product half nonzero.
    - Else: 0.
  - V: signed overflow for ADD/SUB, else 0.
- start while busy=1 is ignored; it is not queued.
- Operands are captured at start. Changes on Data_A/Data_B during busy have no effect.
- dest_sel ≥ 35 or equal to NULL_SEL is legal: done still pulses, and the bank ignores the write.

Test Plan:
- Reset then idle 5 cycles -> busy=0, done=0, Sel_C=63, Data_C=0, flags=0000 throughout.
- ADD A=0x7FFF, B=0x0001, dest=5 -> done two cycles after the start edge; Sel_C=5, Data_C=0x8000, flags Z0 N1 C0 V1 for exactly one cycle; Sel_C=63 in the next cycle.
- SUB A=0x0003, B=0x0005, dest=2 -> Data_C=0xFFFE, C=1, N=1.
- Back-to-back: SUB A=0x0003, B=0x0003, dest=1, then PASS A during its DONE cycle -> Data_C=0x0000 with Z=1. The second op is accepted in the DONE cycle and produces its own DONE two cycles later.
- SHL A=0x8001, B=0x0004, dest=7 -> busy for 5 cycles; Data_C=0x0010, C=0 (last bit out = A[12]). Repeat with B=0 -> L=0, Data_C=0x8001, C=0.
- MUL A=0x0100, B=0x0300, dest=9 -> done 18 cycles after start; Data_C=0x0000, Z=1, C=1. Mid-ITER nreset=0 -> outputs reset immediately; no DONE and no write with Sel_C=9 follow.
- start pulsed during busy, and Data_A/B changes during busy -> ignored; the in-flight result is unchanged.
